irq_controller_vec: RTL

- Parametrised multi-source successor to the single-line interrupt controller in the interrupt subsystem.
- Accepts N_IRQ request lines, each independently edge- or level-sensitive, with per-source enable.
- Latches edge events into pending bits and selects the lowest-index eligible source by fixed priority.
- Drives the CSR/trap logic with a one-cycle irq pulse, a vectored mcause value and irq_ret on mret; keeps the exception-over-interrupt handling semantics.

---
 rtl/irq_pkg.sv | 9 +
 rtl/irq_prio_enc.sv | 27 ++
 rtl/irq_controller_vec.sv | 89 ++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared constants for the vectored interrupt controller: cause base,
// source-count ceiling and the default edge/level split.
package irq_pkg;

    localparam logic [31:0] IRQ_CAUSE_BASE    = 32'h8000_0010;
    localparam int          MAX_IRQ           = 32;
    localparam logic [31:0] DEFAULT_EDGE_MASK = 32'h0000_FFFF;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit of the eligible vector wins.
// Purely combinational; reports a valid flag, the binary index and a one-hot.
module irq_prio_enc #(
    parameter int N  = 16,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    output logic          valid,
    output logic [IW-1:0] index,
    output logic [N-1:0]  onehot
);

    always_comb begin
        valid = |eligible;
        index = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                index = IW'(i);
            end
        end
    end

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = eligible & (~eligible + {{(N-1){1'b0}}, 1'b1});

endmodule

// File: rtl/irq_controller_vec.sv
// Multi-source interrupt controller: per-source edge/level capture, fixed
// priority selection, vectored mcause and exception-over-interrupt tracking.
module irq_controller_vec
    import irq_pkg::*;
#(
    parameter int          N_IRQ      = 16,
    parameter logic [31:0] EDGE_MASK  = DEFAULT_EDGE_MASK,
    parameter logic [31:0] CAUSE_BASE = IRQ_CAUSE_BASE
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             exception_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic [N_IRQ-1:0] irq_en_i,
    input  logic             mie_i,
    input  logic             mret_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_IRQ-1:0] irq_ack_o,
    output logic             irq_ret_o,
    output logic [N_IRQ-1:0] pending_o
);

    localparam int               IW     = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam logic [N_IRQ-1:0] EDGE_M = EDGE_MASK[N_IRQ-1:0];

    logic             exc_h_reg, exc_h_next;
    logic             irq_h_reg, irq_h_next;
    logic [N_IRQ-1:0] req_q_reg;
    logic [N_IRQ-1:0] pend_q_reg, pend_q_next;
    logic [31:0]      cause_q_reg;

    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] rise;
    logic             sel_valid;
    logic [IW-1:0]    sel_idx;
    logic [N_IRQ-1:0] sel_onehot;
    logic             busy;
    logic [31:0]      taken_cause;

    // Level sources bypass the latch; everything is forced quiet while in reset.
    assign pending   = rst_i ? ((pend_q_reg & EDGE_M) | (irq_req_i & ~EDGE_M)) : '0;
    assign pending_o = pending;
    assign eligible  = pending & irq_en_i;

    irq_prio_enc #(
        .N  (N_IRQ),
        .IW (IW)
    ) u_prio_enc (
        .eligible (eligible),
        .valid    (sel_valid),
        .index    (sel_idx),
        .onehot   (sel_onehot)
    );

    assign busy        = irq_h_reg | exc_h_reg | exception_i;
    assign irq_o       = mie_i & sel_valid & ~busy;
    assign irq_ack_o   = irq_o ? sel_onehot : '0;
    assign taken_cause = CAUSE_BASE + 32'(sel_idx);
    assign irq_cause_o = irq_o ? taken_cause : cause_q_reg;

    // An mret belongs to the exception handler while one is active or starting.
    assign irq_ret_o   = rst_i & mret_i & ~(exception_i | exc_h_reg);

    assign rise        = irq_req_i & ~req_q_reg;
    assign pend_q_next = EDGE_M & (rise | (pend_q_reg & ~irq_ack_o));
    assign exc_h_next  = (exception_i | exc_h_reg) & ~mret_i;
    assign irq_h_next  = (irq_o | irq_h_reg) & ~irq_ret_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exc_h_reg   <= 1'b0;
            irq_h_reg   <= 1'b0;
            req_q_reg   <= '0;
            pend_q_reg  <= '0;
            cause_q_reg <= CAUSE_BASE;
        end else begin
            exc_h_reg  <= exc_h_next;
            irq_h_reg  <= irq_h_next;
            req_q_reg  <= irq_req_i;
            pend_q_reg <= pend_q_next;
            if (irq_o) begin
                cause_q_reg <= taken_cause;
            end
        end
    end

endmodule
